nn_axis_out_streamer: RTL and testbench

- AXI-Stream master transmitter that returns final-layer neuron outputs to the host. It is the outbound counterpart of the network's AXI-Stream input port.
- Captures the parallel output vector of the last Layer on its valid pulse and serializes it one neuron per beat.
- Honours tready back-pressure and marks frame boundaries with tuser (first beat) and tlast (last beat).
- Holds one pending vector so back-to-back inferences are not lost; counts and flags drops when both buffers are occupied.

---
 rtl/nn_axis_out_streamer.sv | 129 ++++++++++++
 tb/tb_nn_axis_out_streamer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nn_axis_out_streamer.sv
// rtl/nn_axis_out_streamer.sv - AXI-Stream master that serializes final-layer output vectors one neuron per beat
module nn_axis_out_streamer #(
    parameter int NUM_OUT    = 10,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic [NUM_OUT*DATA_WIDTH-1:0] i_data,
    input  logic                          i_valid,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [CNT_WIDTH-1:0]          o_drop_count,
    input  logic                          i_clear_overflow
);

    localparam int VW = NUM_OUT * DATA_WIDTH;
    localparam int BW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_OUT - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]    state, state_n;
    logic [VW-1:0] active, active_n;
    logic [VW-1:0] pending, pending_n;
    logic          pend_full, pend_full_n;
    logic [BW-1:0] beat, beat_n;
    logic          handshake, last_handshake, drop;

    assign handshake      = (state == SEND) && m_axis_tready;
    assign last_handshake = handshake && (beat == LAST_BEAT);

    // Next-state: frame sequencing, pending buffer and drop decision
    always_comb begin
        state_n     = state;
        active_n    = active;
        pending_n   = pending;
        pend_full_n = pend_full;
        beat_n      = beat;
        drop        = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_n  = SEND;
                    active_n = i_data;
                    beat_n   = '0;
                end
            end
            SEND: begin
                if (last_handshake) begin
                    // Chain straight into the next frame when one is queued so the stream has no bubble
                    if (pend_full) begin
                        active_n = pending;
                        beat_n   = '0;
                        if (i_valid) pending_n = i_data;
                        else         pend_full_n = 1'b0;
                    end else if (i_valid) begin
                        active_n = i_data;
                        beat_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        active_n = active >> DATA_WIDTH;
                        beat_n   = beat + BW'(1);
                    end
                    if (i_valid) begin
                        if (!pend_full) begin
                            pending_n   = i_data;
                            pend_full_n = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered stream sideband; tuser/tlast are precomputed from the next beat index
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= IDLE;
            active        <= '0;
            pending       <= '0;
            pend_full     <= 1'b0;
            beat          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_n;
            active        <= active_n;
            pending       <= pending_n;
            pend_full     <= pend_full_n;
            beat          <= beat_n;
            m_axis_tvalid <= (state_n == SEND);
            m_axis_tuser  <= (state_n == SEND) && (beat_n == '0);
            m_axis_tlast  <= (state_n == SEND) && (beat_n == LAST_BEAT);
            o_busy        <= (state_n == SEND) || pend_full_n;
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop wins over a same-cycle clear
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
        end else if (i_clear_overflow) begin
            o_overflow   <= drop;
            o_drop_count <= drop ? CNT_WIDTH'(1) : '0;
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (o_drop_count != '1) o_drop_count <= o_drop_count + CNT_WIDTH'(1);
        end
    end

    assign m_axis_tdata = active[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_nn_axis_out_streamer.sv
// tb/tb_nn_axis_out_streamer.sv - directed and randomized check of nn_axis_out_streamer against a beat-queue model
module tb_nn_axis_out_streamer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 3;
    localparam int VW = N * DW;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [VW-1:0] i_data;
    logic          i_valid;
    logic [DW-1:0] tdata;
    logic          tvalid, tready, tlast, tuser;
    logic          busy, overflow, clr;
    logic [CW-1:0] drop_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] d;
        bit            u;
        bit            l;
    } beat_t;

    beat_t         q[$];
    logic [VW-1:0] m_pend;
    bit            m_pend_v;
    bit            m_ovf;
    int            m_cnt;

    nn_axis_out_streamer #(.NUM_OUT(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .s_axi_aclk       (clk),
        .s_axi_aresetn    (rst_n),
        .i_data           (i_data),
        .i_valid          (i_valid),
        .m_axis_tdata     (tdata),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .m_axis_tlast     (tlast),
        .m_axis_tuser     (tuser),
        .o_busy           (busy),
        .o_overflow       (overflow),
        .o_drop_count     (drop_count),
        .i_clear_overflow (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [VW-1:0] v);
        for (int i = 0; i < N; i++) begin
            beat_t b;
            b.d = v[i*DW +: DW];
            b.u = (i == 0);
            b.l = (i == N - 1);
            q.push_back(b);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend_v = 0;
        m_pend   = '0;
        m_ovf    = 0;
        m_cnt    = 0;
    endtask

    // Frame-level reference: active frame is a queue of remaining beats, plus one pending vector
    task automatic model_edge(input bit v, input logic [VW-1:0] d, input bit r, input bit c);
        bit drop = 0;
        if (q.size() == 0) begin
            if (v) push_frame(d);
        end else begin
            bit last_hs = r && q[0].l;
            if (r) void'(q.pop_front());
            if (last_hs) begin
                if (m_pend_v) begin
                    push_frame(m_pend);
                    m_pend_v = v;
                    m_pend   = d;
                end else if (v) begin
                    push_frame(d);
                end
            end else if (v) begin
                if (!m_pend_v) begin
                    m_pend_v = 1;
                    m_pend   = d;
                end else begin
                    drop = 1;
                end
            end
        end
        if (c) begin
            m_ovf = drop;
            m_cnt = drop ? 1 : 0;
        end else if (drop) begin
            m_ovf = 1;
            if (m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic compare_all();
        check("tvalid", tvalid, q.size() > 0);
        if (q.size() > 0) begin
            check("tdata", tdata, q[0].d);
            check("tuser", tuser, q[0].u);
            check("tlast", tlast, q[0].l);
        end
        check("busy", busy, (q.size() > 0) || m_pend_v);
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, m_cnt);
    endtask

    task automatic step(input bit v, input logic [VW-1:0] d, input bit r, input bit c);
        i_valid = v;
        i_data  = d;
        tready  = r;
        clr     = c;
        @(posedge clk);
        model_edge(v, d, r, c);
        #1;
        compare_all();
    endtask

    task automatic reset_now();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        clr     = 1'b0;
        #1;
        model_reset();
        check("rst_tvalid", tvalid, 0);
        check("rst_tuser", tuser, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [VW-1:0] v1, v2;
        logic [6:0] bp;
        v1 = 64'h0004_0003_0002_0001;
        v2 = 64'h000D_000C_000B_000A;
        rst_n = 1'b0; i_valid = 0; i_data = '0; tready = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_now();

        // Basic frame with sink always ready
        step(1, v1, 1, 0);
        repeat (6) step(0, '0, 1, 0);

        // Back-pressure pattern 1,0,0,1,0,1,1
        bp = 7'b1101001;
        step(1, 64'h1111_2222_3333_4444, 0, 0);
        for (int i = 0; i < 7; i++) step(0, '0, bp[i], 0);
        repeat (3) step(0, '0, 1, 0);

        // Back-to-back: second vector lands during beat 1
        step(1, v1, 1, 0);
        step(0, '0, 1, 0);
        step(1, v2, 1, 0);
        repeat (9) step(0, '0, 1, 0);

        // Overflow: three pulses under back-pressure, then drain and clear
        step(1, v1, 0, 0);
        step(1, v2, 0, 0);
        step(1, 64'h0EEE_0EEE_0EEE_0EEE, 0, 0);
        step(0, '0, 0, 0);
        repeat (10) step(0, '0, 1, 0);
        step(0, '0, 1, 1);

        // Reset mid-frame after beat 1, then a fresh frame
        step(1, v2, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        reset_now();
        step(1, v1, 1, 0);
        repeat (5) step(0, '0, 1, 0);

        // New vector coincident with last-beat handshake, pending empty
        step(1, v1, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(1, v2, 1, 0);
        repeat (5) step(0, '0, 1, 0);

        // Randomized traffic, rare clears so the counter saturates
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), {$urandom, $urandom},
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 400) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
